audiosystem_vga_timing: RTL and testbench

Pixel-domain timing generator that consumes the 25 MHz pixel clock and PLL lock indication from the VGA clock block. It holds the display idle until lock is stable, then produces 640x480@60 Hz hsync/vsync, active-video flag, pixel coordinates and frame/line strobes for the audio visualiser's pixel pipeline. If lock is lost, it returns to idle and restarts cleanly at frame origin.

---
 rtl/audiosystem_vga_pkg.sv | 27 ++
 rtl/audiosystem_vga_sync_counter.sv | 51 +++++
 rtl/audiosystem_vga_timing.sv | 122 ++++++++++++
 tb/tb_audiosystem_vga_timing.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/audiosystem_vga_pkg.sv
// Shared VGA timing defaults, FSM state codes and line/frame total helper.
// Constants only; no clocked logic.
package audiosystem_vga_pkg;

  localparam int CNT_W     = 10;
  localparam int MAX_TOTAL = 1 << CNT_W;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef logic [1:0] state_t;

  localparam state_t ST_WAIT_LOCK = 2'd0;
  localparam state_t ST_SETTLE    = 2'd1;
  localparam state_t ST_RUN       = 2'd2;

  function automatic int timing_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/audiosystem_vga_sync_counter.sv
// Wrapping position counter with clear/enable; sync and active decodes are of the next count
// so the parent can register them in step with the counter itself.
module audiosystem_vga_sync_counter
  import audiosystem_vga_pkg::*;
#(
  parameter int TOTAL      = 800,
  parameter int ACTIVE     = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_LEN   = 96
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o,
  output logic             sync_nxt_o,
  output logic             act_nxt_o
);

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(SYNC_START);
  localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(SYNC_START + SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] ACT_END = CNT_W'(ACTIVE);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign wrap_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign sync_nxt_o = (cnt_d >= SYNC_LO) && (cnt_d <= SYNC_HI);
  assign act_nxt_o  = (cnt_d < ACT_END);

endmodule

// File: rtl/audiosystem_vga_timing.sv
// 640x480@60 VGA timing generator gated by a debounced PLL lock; all outputs registered and
// mutually aligned, lock loss returns to idle on the very next cycle.
module audiosystem_vga_timing
  import audiosystem_vga_pkg::*;
#(
  parameter int H_ACTIVE        = DEF_H_ACTIVE,
  parameter int H_FP            = DEF_H_FP,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BP            = DEF_H_BP,
  parameter int V_ACTIVE        = DEF_V_ACTIVE,
  parameter int V_FP            = DEF_V_FP,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BP            = DEF_V_BP,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int SETTLE_CYCLES   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             locked,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic [CNT_W-1:0] px_x,
  output logic [CNT_W-1:0] px_y,
  output logic             line_start,
  output logic             frame_start,
  output logic             running
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic       SYNC_OFF    = SYNC_ACTIVE_LOW;
  localparam logic       SYNC_ON     = ~SYNC_OFF;
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  generate
    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
      $error("audiosystem_vga_timing: H_TOTAL/V_TOTAL must not exceed 1024");
    end
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
      $error("audiosystem_vga_timing: SETTLE_CYCLES must be 1..255");
    end
  endgenerate

  state_t     state_q, state_d;
  logic [7:0] settle_q, settle_d;

  always_comb begin
    state_d  = state_q;
    settle_d = '0;
    case (state_q)
      ST_WAIT_LOCK: if (locked) state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (!locked) begin
          state_d = ST_WAIT_LOCK;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = ST_RUN;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      ST_RUN:  if (!locked) state_d = ST_WAIT_LOCK;
      default: state_d = ST_WAIT_LOCK;
    endcase
  end

  logic run_q, run_d, cnt_en, cnt_clr;
  logic h_wrap, v_wrap, h_sync_d, v_sync_d, h_act_d, v_act_d;

  assign run_q   = (state_q == ST_RUN);
  assign run_d   = (state_d == ST_RUN);
  // Counters sit at the origin outside RUN, so entry into RUN needs no extra load.
  assign cnt_en  = run_q && run_d;
  assign cnt_clr = !run_d;

  audiosystem_vga_sync_counter #(
    .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE), .SYNC_START(H_ACTIVE + H_FP), .SYNC_LEN(H_SYNC)
  ) u_hcnt (
    .clk(clk), .rst(rst), .clr_i(cnt_clr), .en_i(cnt_en),
    .cnt_o(px_x), .wrap_o(h_wrap), .sync_nxt_o(h_sync_d), .act_nxt_o(h_act_d)
  );

  audiosystem_vga_sync_counter #(
    .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE), .SYNC_START(V_ACTIVE + V_FP), .SYNC_LEN(V_SYNC)
  ) u_vcnt (
    .clk(clk), .rst(rst), .clr_i(cnt_clr), .en_i(cnt_en && h_wrap),
    .cnt_o(px_y), .wrap_o(v_wrap), .sync_nxt_o(v_sync_d), .act_nxt_o(v_act_d)
  );

  logic hsync_q, vsync_q, active_q, line_start_q, frame_start_q, running_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_WAIT_LOCK;
      settle_q      <= '0;
      hsync_q       <= SYNC_OFF;
      vsync_q       <= SYNC_OFF;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_q      <= settle_d;
      hsync_q       <= (run_d && h_sync_d) ? SYNC_ON : SYNC_OFF;
      vsync_q       <= (run_d && v_sync_d) ? SYNC_ON : SYNC_OFF;
      active_q      <= run_d && h_act_d && v_act_d;
      line_start_q  <= run_d && (!run_q || h_wrap);
      frame_start_q <= run_d && (!run_q || (h_wrap && v_wrap));
      running_q     <= run_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign running     = running_q;

endmodule

// File: tb/tb_audiosystem_vga_timing.sv
// Random-lock bench for audiosystem_vga_timing against a cycle-count reference model,
// using a reduced raster so several whole frames fit in a short run.
module tb_audiosystem_vga_timing;

  localparam int H_A = 40, H_F = 6, H_S = 8, H_B = 10;
  localparam int V_A = 12, V_F = 3, V_S = 2, V_B = 4;
  localparam int SETTLE = 16;
  localparam int H_T = H_A + H_F + H_S + H_B;
  localparam int V_T = V_A + V_F + V_S + V_B;
  localparam int FRAME = H_T * V_T;
  localparam logic [31:0] IDLE = {6'd0, 1'b0, 1'b1, 1'b1, 3'b000, 10'd0, 10'd0};

  logic       clk = 1'b0;
  logic       rst, locked;
  logic       hsync, vsync, active, line_start, frame_start, running;
  logic [9:0] px_x, px_y;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: lock streak while idle, elapsed RUN cycles while running.
  bit m_run    = 1'b0;
  int m_streak = 0;
  int m_t      = 0;

  audiosystem_vga_timing #(
    .H_ACTIVE(H_A), .H_FP(H_F), .H_SYNC(H_S), .H_BP(H_B),
    .V_ACTIVE(V_A), .V_FP(V_F), .V_SYNC(V_S), .V_BP(V_B),
    .SYNC_ACTIVE_LOW(1'b1), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .locked(locked),
    .hsync(hsync), .vsync(vsync), .active(active),
    .px_x(px_x), .px_y(px_y),
    .line_start(line_start), .frame_start(frame_start), .running(running)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] dut_vec();
    return {6'd0, running, hsync, vsync, active, line_start, frame_start, px_x, px_y};
  endfunction

  function automatic logic [31:0] exp_vec();
    int x, y;
    logic hs_on, vs_on, act, ls, fs;
    if (!m_run) return IDLE;
    x     = m_t % H_T;
    y     = (m_t / H_T) % V_T;
    hs_on = (x >= H_A + H_F) && (x < H_A + H_F + H_S);
    vs_on = (y >= V_A + V_F) && (y < V_A + V_F + V_S);
    act   = (x < H_A) && (y < V_A);
    ls    = (x == 0);
    fs    = (m_t % FRAME) == 0;
    return {6'd0, 1'b1, !hs_on, !vs_on, act, ls, fs, 10'(x), 10'(y)};
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_run = 1'b0; m_streak = 0; m_t = 0;
    end else if (m_run) begin
      if (locked) m_t++;
      else begin m_run = 1'b0; m_streak = 0; end
    end else if (locked) begin
      m_streak++;
      if (m_streak == SETTLE + 1) begin m_run = 1'b1; m_t = 0; m_streak = 0; end
    end else begin
      m_streak = 0;
    end
    @(negedge clk);
    check_eq("cycle", dut_vec(), exp_vec());
  endtask

  task automatic measure_rise(output int n);
    n = 0;
    while (!running && n <= 100) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n, low_cnt, hs_low, vs_low, act_cnt, ls_cnt, fs_cnt;
    bit found, run_seen;

    rst = 1'b1;
    locked = 1'b0;
    #1 check_eq("reset_state", dut_vec(), IDLE);
    repeat (3) step();

    rst = 1'b0;
    locked = 1'b1;
    measure_rise(n);
    check_eq("settle_latency", 32'(n), 32'(SETTLE + 1));
    check_eq("first_run_cycle", {27'd0, frame_start, line_start, active, px_x == 10'd0, px_y == 10'd0}, 32'h1F);

    hs_low = 0; vs_low = 0; act_cnt = 0; ls_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      hs_low  += int'(!hsync);
      vs_low  += int'(!vsync);
      act_cnt += int'(active);
      ls_cnt  += int'(line_start);
      fs_cnt  += int'(frame_start);
    end
    check_eq("hsync_low_cycles", 32'(hs_low), 32'(3 * V_T * H_S));
    check_eq("vsync_low_cycles", 32'(vs_low), 32'(3 * V_S * H_T));
    check_eq("active_cycles", 32'(act_cnt), 32'(3 * H_A * V_A));
    check_eq("line_starts", 32'(ls_cnt), 32'(3 * V_T));
    check_eq("frame_starts", 32'(fs_cnt), 32'd3);

    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (px_x == 10'd30 && px_y == 10'd7) found = 1'b1;
      else step();
    end
    check_eq("find_pos", 32'(found), 32'd1);
    locked = 1'b0;
    step();
    check_eq("drop_idle", dut_vec(), IDLE);
    locked = 1'b1;
    measure_rise(n);
    check_eq("resettle_latency", 32'(n), 32'(SETTLE + 1));
    check_eq("restart_frame_start", {31'd0, frame_start}, 32'd1);

    locked = 1'b0;
    step();
    run_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      locked = ~locked;
      repeat (8) begin
        step();
        run_seen |= running;
      end
    end
    check_eq("toggle_no_run", 32'(run_seen), 32'd0);

    low_cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      if (low_cnt > 0) begin
        locked = 1'b0;
        low_cnt--;
      end else begin
        locked = 1'b1;
        if ($urandom_range(0, 299) == 0) low_cnt = int'($urandom_range(1, 20));
      end
      step();
    end

    locked = 1'b1;
    measure_rise(n);
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (px_y == 10'd5 && px_x == 10'd20) found = 1'b1;
      else step();
    end
    check_eq("find_mid_frame", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1 check_eq("async_reset", dut_vec(), IDLE);
    repeat (2) step();
    rst = 1'b0;
    measure_rise(n);
    check_eq("post_reset_latency", 32'(n), 32'(SETTLE + 1));
    repeat (50) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
